// File: rtl/diferential_muxpga_grid.sv
// diferential_muxpga_grid: ROWS x COLS torus of registered logic cells with a
// shadow configuration chain loaded serially and committed atomically.
// Optional readback tap: define DIFERENTIAL_MUXPGA_READBACK_EN to add cfg_out.
module diferential_muxpga_grid #(
    parameter int unsigned ROWS = 3,
    parameter int unsigned COLS = 3,
    parameter int unsigned BITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [BITS-1:0]        ext_in,
    input  logic                   cfg_start,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic                   cfg_busy,
    output logic                   cfg_done,
`ifdef DIFERENTIAL_MUXPGA_READBACK_EN
    output logic                   cfg_out,
`endif
    output logic [ROWS*BITS-1:0]   col_out
);

    localparam int unsigned CELLS = ROWS * COLS;
    localparam int unsigned N     = 6 * CELLS;
    localparam int unsigned CW    = $clog2(N + 1);
    localparam int unsigned QW    = CELLS * BITS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    cfg_a;
    logic [N-1:0]    cfg_s;
    logic [QW-1:0]   q;
    logic [QW-1:0]   f;
    logic            accept_c;

    // Input selection shared by both cell operands
    function automatic logic [BITS-1:0] pick(
        input logic [1:0]      s,
        input logic [BITS-1:0] n,
        input logic [BITS-1:0] nw,
        input logic [BITS-1:0] w,
        input logic [BITS-1:0] e
    );
        case (s)
            2'd0:    return n;
            2'd1:    return nw;
            2'd2:    return w;
            default: return e;
        endcase
    endfunction

    assign accept_c = (state == LOAD) && cfg_valid && !cfg_start;

    // Configuration loader: shadow shift, bit count and atomic commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cfg_a    <= '0;
            cfg_s    <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state    <= LOAD;
                        cnt      <= '0;
                        cfg_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        cnt <= '0;
                    end else if (cfg_valid) begin
                        cfg_s <= {cfg_s[N-2:0], cfg_bit};
                        cnt   <= cnt + CW'(1);
                        if (cnt == CW'(N - 1)) begin
                            state <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    cfg_a    <= cfg_s;
                    cfg_done <= 1'b1;
                    cfg_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef DIFERENTIAL_MUXPGA_READBACK_EN
    // Readback tap: the bit falling off the chain, advanced per accepted bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_out <= 1'b0;
        end else if (accept_c) begin
            cfg_out <= cfg_s[N-1];
        end
    end
`else
    logic unused_accept_c;
    assign unused_accept_c = accept_c;
`endif

    // Per-cell neighbour muxing and function evaluation
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int unsigned K   = r * COLS + c;
            localparam int unsigned C_W = (c + COLS - 1) % COLS;
            localparam int unsigned C_E = (c + 1) % COLS;

            logic [5:0]      fld;
            logic [BITS-1:0] n_v, nw_v, w_v, e_v;
            logic [BITS-1:0] in1, in2, res;

            assign fld = cfg_a[6*K +: 6];

            if (r == 0) begin : g_top
                assign n_v  = ext_in;
                assign nw_v = ext_in;
            end else begin : g_inner
                assign n_v  = q[((r - 1) * COLS + c) * BITS +: BITS];
                assign nw_v = q[((r - 1) * COLS + C_W) * BITS +: BITS];
            end

            assign w_v = q[(r * COLS + C_W) * BITS +: BITS];
            assign e_v = q[(r * COLS + C_E) * BITS +: BITS];

            // Cell logic function
            always_comb begin
                in1 = pick(fld[1:0], n_v, nw_v, w_v, e_v);
                in2 = pick(fld[3:2], n_v, nw_v, w_v, e_v);
                case (fld[5:4])
                    2'd0:    res = in1 & in2;
                    2'd1:    res = in1 | in2;
                    2'd2:    res = in1;
                    default: res = in2;
                endcase
            end

            assign f[K*BITS +: BITS] = res;
        end
    end

    // Cell registers advance together only while run is high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (run) begin
            q <= f;
        end
    end

    // Export the last column of every row
    for (genvar r = 0; r < ROWS; r++) begin : g_out
        assign col_out[r*BITS +: BITS] = q[(r * COLS + COLS - 1) * BITS +: BITS];
    end

endmodule

// File: tb/tb_diferential_muxpga_grid.sv
// Directed testbench for diferential_muxpga_grid (ROWS = COLS = BITS = 3, N = 54).
module tb_diferential_muxpga_grid;

    localparam int unsigned ROWS = 3;
    localparam int unsigned COLS = 3;
    localparam int unsigned BITS = 3;
    localparam int          N    = 54;

    localparam logic [53:0] CFG_PIPE = {9{6'b100000}};
    localparam logic [53:0] CFG_WEST = {9{6'b100010}};
    localparam logic [53:0] CFG_MIX  = {{6{6'b011000}}, {3{6'b001000}}};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic [2:0] ext_in = 3'b000;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       cfg_busy;
    logic       cfg_done;
`ifdef DIFERENTIAL_MUXPGA_READBACK_EN
    logic       cfg_out;
`endif
    logic [8:0] col_out;

    int tests = 0;
    int fails = 0;

    diferential_muxpga_grid #(.ROWS(ROWS), .COLS(COLS), .BITS(BITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .ext_in    (ext_in),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
`ifdef DIFERENTIAL_MUXPGA_READBACK_EN
        .cfg_out   (cfg_out),
`endif
        .col_out   (col_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted configuration bit; busy must hold and no early done
    task automatic send_bit(input logic b);
        cfg_valid = 1'b1;
        cfg_bit   = b;
        tick();
        cfg_valid = 1'b0;
        tests++;
        if (cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin
            fails++;
            $display("FAIL load_bit: busy=%b done=%b, required busy=1 done=0", cfg_busy, cfg_done);
        end
    endtask

    // Start pulse then N bits, MSB first; returns right after the Nth bit edge
    task automatic load_cfg(input logic [53:0] v, input bit gap);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (gap && i != N - 1) begin
                tick();
                tests++;
                if (cfg_busy !== 1'b1) begin
                    fails++;
                    $display("FAIL gap_busy: busy=%b, required 1", cfg_busy);
                end
            end
            send_bit(v[i]);
        end
    endtask

    // Commit edge: done pulses for exactly one cycle, busy drops
    task automatic finish_commit();
        tick();
        tests++;
        if (cfg_done !== 1'b1 || cfg_busy !== 1'b0) begin
            fails++;
            $display("FAIL commit: done=%b busy=%b, required done=1 busy=0", cfg_done, cfg_busy);
        end
        tick();
        tests++;
        if (cfg_done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse: done=%b, required 0", cfg_done);
        end
    endtask

    task automatic test_reset();
        tick();
        tests++;
        if (col_out !== 9'h000 || cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: col=%h busy=%b done=%b, required 000/0/0", col_out, cfg_busy, cfg_done);
        end
        reset  = 1'b0;
        run    = 1'b1;
        ext_in = 3'b111;
        repeat (3) tick();
        tests++;
        if (col_out !== 9'h1FF) begin
            fails++;
            $display("FAIL reset_prefill: col=%h, required 1ff", col_out);
        end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        #4 reset = 1'b1;
        #1;
        tests++;
        if (col_out !== 9'h000 || cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: col=%h busy=%b done=%b, required 000/0/0", col_out, cfg_busy, cfg_done);
        end
`ifdef DIFERENTIAL_MUXPGA_READBACK_EN
        tests++;
        if (cfg_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_cfg_out: got %b, required 0", cfg_out);
        end
`endif
        #1 reset = 1'b0;
        tick();
    endtask

    task automatic test_vertical_pipe();
        run = 1'b1;
        ext_in = 3'b000;
        load_cfg(CFG_PIPE, 1'b0);
        finish_commit();
        repeat (3) tick();
        tests++;
        if (col_out !== 9'h000) begin
            fails++;
            $display("FAIL pipe_flush: col=%h, required 000", col_out);
        end
        ext_in = 3'b101;
        tick();
        tests++;
        if (col_out !== 9'h005) begin
            fails++;
            $display("FAIL pipe_hop1: col=%h, required 005", col_out);
        end
        tick();
        tests++;
        if (col_out !== 9'h02D) begin
            fails++;
            $display("FAIL pipe_hop2: col=%h, required 02d", col_out);
        end
        tick();
        tests++;
        if (col_out !== 9'h16D) begin
            fails++;
            $display("FAIL pipe_hop3: col=%h, required 16d", col_out);
        end
    endtask

    task automatic test_gapped_load();
        ext_in = 3'b110;
        repeat (3) tick();
        tests++;
        if (col_out !== 9'h1B6) begin
            fails++;
            $display("FAIL gap_prefill: col=%h, required 1b6", col_out);
        end
        load_cfg(CFG_WEST, 1'b1);
        tests++;
        if (cfg_done !== 1'b0 || col_out !== 9'h1B6) begin
            fails++;
            $display("FAIL gap_before_commit: done=%b col=%h, required 0/1b6", cfg_done, col_out);
        end
        ext_in = 3'b001;
        tick();
        tests++;
        if (cfg_done !== 1'b1 || cfg_busy !== 1'b0 || col_out !== 9'h1B1) begin
            fails++;
            $display("FAIL gap_commit: done=%b busy=%b col=%h, required 1/0/1b1", cfg_done, cfg_busy, col_out);
        end
        tick();
        tests++;
        if (cfg_done !== 1'b0 || col_out !== 9'h1B1) begin
            fails++;
            $display("FAIL gap_new_cfg: done=%b col=%h, required 0/1b1", cfg_done, col_out);
        end
        tick();
        tests++;
        if (col_out !== 9'h1B1) begin
            fails++;
            $display("FAIL gap_rotate: col=%h, required 1b1", col_out);
        end
    endtask

    task automatic test_abort();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        tests++;
        if (cfg_busy !== 1'b1 || cfg_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: busy=%b done=%b, required 1/0", cfg_busy, cfg_done);
        end
        for (int i = N - 1; i >= 0; i--) send_bit(CFG_PIPE[i]);
        finish_commit();
        ext_in = 3'b010;
        repeat (3) begin
            tick();
            tests++;
            if (cfg_done !== 1'b0) begin
                fails++;
                $display("FAIL abort_extra_done: done=%b, required 0", cfg_done);
            end
        end
        tests++;
        if (col_out !== 9'h092) begin
            fails++;
            $display("FAIL abort_cfg: col=%h, required 092", col_out);
        end
    endtask

    task automatic test_reset_mid_load();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 30; i++) send_bit(1'b1);
        #4 reset = 1'b1;
        #1;
        tests++;
        if (cfg_busy !== 1'b0 || cfg_done !== 1'b0 || col_out !== 9'h000) begin
            fails++;
            $display("FAIL midload_reset: busy=%b done=%b col=%h, required 0/0/000", cfg_busy, cfg_done, col_out);
        end
        #1 reset = 1'b0;
        tick();
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            tests++;
            if (cfg_busy !== 1'b0 || cfg_done !== 1'b0) begin
                fails++;
                $display("FAIL idle_ignores_valid: busy=%b done=%b, required 0/0", cfg_busy, cfg_done);
            end
        end
        cfg_valid = 1'b0;
        ext_in = 3'b011;
        repeat (3) tick();
        tests++;
        if (col_out !== 9'h0DB) begin
            fails++;
            $display("FAIL midload_default_cfg: col=%h, required 0db", col_out);
        end
    endtask

    task automatic test_functions_and_hold();
        ext_in = 3'b001; tick();
        ext_in = 3'b010; tick();
        ext_in = 3'b100; tick();
        tests++;
        if (col_out !== 9'h054) begin
            fails++;
            $display("FAIL fn_prefill: col=%h, required 054", col_out);
        end
        run = 1'b0;
        ext_in = 3'b111;
        load_cfg(CFG_MIX, 1'b0);
        finish_commit();
        tests++;
        if (col_out !== 9'h054) begin
            fails++;
            $display("FAIL hold_through_commit: col=%h, required 054", col_out);
        end
        run = 1'b1;
        ext_in = 3'b011;
        tick();
        tests++;
        if (col_out !== 9'h0F0) begin
            fails++;
            $display("FAIL fn_edge1: col=%h, required 0f0", col_out);
        end
        tick();
        tests++;
        if (col_out !== 9'h1F0) begin
            fails++;
            $display("FAIL fn_edge2: col=%h, required 1f0", col_out);
        end
        tick();
        tests++;
        if (col_out !== 9'h1F0) begin
            fails++;
            $display("FAIL fn_edge3: col=%h, required 1f0", col_out);
        end
        run = 1'b0;
        ext_in = 3'b111;
        repeat (2) tick();
        tests++;
        if (col_out !== 9'h1F0) begin
            fails++;
            $display("FAIL run_hold: col=%h, required 1f0", col_out);
        end
    endtask

`ifdef DIFERENTIAL_MUXPGA_READBACK_EN
    task automatic test_readback();
        #4 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 1; i <= N; i++) begin
            send_bit(i == 1);
            tests++;
            if (cfg_out !== 1'b0) begin
                fails++;
                $display("FAIL readback_early bit %0d: got %b, required 0", i, cfg_out);
            end
        end
        finish_commit();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        send_bit(1'b1);
        tests++;
        if (cfg_out !== 1'b1) begin
            fails++;
            $display("FAIL readback_bit55: got %b, required 1", cfg_out);
        end
        send_bit(1'b0);
        tests++;
        if (cfg_out !== 1'b0) begin
            fails++;
            $display("FAIL readback_bit56: got %b, required 0", cfg_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vertical_pipe();
        test_gapped_load();
        test_abort();
        test_reset_mid_load();
        test_functions_and_hold();
`ifdef DIFERENTIAL_MUXPGA_READBACK_EN
        test_readback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
